pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register for the in-order RISC-V core, replacing per-stage hand-written registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Carries a valid bit, a datapath payload and a control field through DEPTH chained slices. It honours hazard-unit `stall` (hold) and `flush` (bubble insertion, for branch/jump redirect). Optional stall/bubble counters support performance analysis.

## Interface
- `DATA_W`, 64, datapath payload width (ALU result, rs2 data, CSR data); never cleared by flush.
- `CTRL_W`, 16, control field width (opcode, funct3, rd, use_rs1/rs2/rd); forced to zero whenever the slice is invalid.
- `DEPTH`, 1, number of chained slices, legal range 1..4.
- `CNT_W`, 32, width of each performance counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: hold every slice this cycle.
- `flush` in 1: kill every slice this cycle; takes priority over `stall`.
- `in_valid` in 1: upstream slot holds a real instruction.
- `in_data` in DATA_W: upstream payload.
- `in_ctrl` in CTRL_W: upstream control field.
- `out_valid` out 1: last slice valid.
- `out_data` out DATA_W: last slice payload.
- `out_ctrl` out CTRL_W: last slice control field.
- `cnt_clr` in 1: synchronous clear of both counters.
- `stall_cnt` out CNT_W: cycles with stall=1 and flush=0.
- `bubble_cnt` out CNT_W: cycles with stall=0 and out_valid=0.

## Operation
- Slice i takes its input from slice i-1. Slice 0 takes its input from `in_*`. Outputs come from slice DEPTH-1.
- Per-slice state: `valid`, `data`, `ctrl`.
- Reset: all `valid`, `data` and `ctrl` go to 0. Hence `out_valid`, `out_data`, `out_ctrl`, `stall_cnt` and `bubble_cnt` all reset to 0.
- Priority at each clock edge is flush, then stall, then advance:
  - flush=1: `valid` <= 0, `ctrl` <= 0, `data` holds its value (no toggling), in all slices.
  - stall=1, flush=0: all slices hold.
  - Advance: `valid` <= source valid.
    - `ctrl` <= source valid ? source ctrl : 0.
    - `data` loads only when source valid = 1; otherwise it holds (data-enable gating).
- Invariant: `valid` = 0 implies `ctrl` = 0 in every slice, every cycle.
- `in_ctrl` and `in_data` are don't-care when `in_valid` = 0.
- Counters:
  - Saturate at all-ones; no wrap.
  - `cnt_clr` clears both counters and has priority over increment.
  - Clear and count are evaluated in the same cycle as the flush/stall decision.

## Timing
- Latency is DEPTH cycles from `in_*` to `out_*` with no stall. Each stall cycle adds one cycle.
- Outputs are fully registered. There is no combinational path from any input to any output.
- A flush asserted in cycle t gives `out_valid` = 0 from t+1. A new `in_valid` sampled at t+1 reaches the output at t+1+DEPTH.
- `stall` and `flush` are sampled every cycle; there is no multi-cycle protocol.
- Reset asserted mid-stream clears outputs immediately (asynchronously). The first valid output after reset release appears DEPTH cycles after the first sampled `in_valid`.

## Configuration
- `PIPE_STAGE_STATS_EN` defined: counters implemented as described above.
- Not defined:
  - Counter logic is removed.
  - `stall_cnt` and `bubble_cnt` are tied to 0.
  - `cnt_clr` is ignored.
  - Ports remain present so the interface stays stable.

## Structure
- Package `pipe_pkg` holds:
  - `PIPE_DEPTH_MAX` = 4.
  - The default widths.
  - Typedef `stage_ctrl_t`, a packed struct of op[4:0], f3[2:0], rd[4:0], use_rs1, use_rs2, use_rd, totalling 16 bits to match `CTRL_W`.
- One sub-module, `pipe_stage_slice`, holds one valid/data/ctrl register with the flush/stall/advance logic. The top generates DEPTH instances plus the counter logic.

## Test plan
- Reset mid-stream (DEPTH=2, both slices valid) -> outputs 0 in the same cycle; counters 0.
- DEPTH=2, no stall, `in_data`=0xA5A5_0000_0000_0001 and `in_ctrl`=0x1234 at cycle 0 -> `out_valid`=1 with the same values at cycle 2 only.
- Stall held for cycles 3–5 with 0x1234 in the last slice -> outputs unchanged through cycle 5; the next item emerges one cycle after release. With stats enabled, `stall_cnt`=3.
- Flush and stall in the same cycle with a valid item (data 0xDEAD, ctrl 0x00FF) -> `out_valid`=0, `out_ctrl`=0, `out_data` still 0xDEAD.
- `in_valid`=0 with `in_ctrl`=0xFFFF and `in_data`=0xFFFF… for 4 cycles -> `out_ctrl`=0 throughout, `out_data` unchanged, `bubble_cnt` +4.
- CNT_W=4, 20 consecutive stall cycles -> `stall_cnt`=15. Then `cnt_clr` pulse -> 0 next cycle. Without `PIPE_STAGE_STATS_EN`, both counters stay 0.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared widths, depth limit and the control-field layout
// carried by pipe_stage_reg through the in-order core's pipeline stages.
package pipe_pkg;

  localparam int PIPE_DEPTH_MAX = 4;
  localparam int PIPE_DATA_W    = 64;
  localparam int PIPE_CTRL_W    = 16;
  localparam int PIPE_CNT_W     = 32;

  // Control field decoded once in ID and carried downstream.
  typedef struct packed {
    logic [4:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    logic       use_rs1;
    logic       use_rs2;
    logic       use_rd;
  } stage_ctrl_t;

  localparam int STAGE_CTRL_BITS = $bits(stage_ctrl_t);

endpackage

// File: rtl/pipe_stage_reg_slice.sv
// pipe_stage_slice: one valid/data/ctrl register of the stage chain.
// Priority is flush, then stall, then advance. The payload only loads
// when a real instruction arrives, so bubbles and flushes never toggle it.
module pipe_stage_slice
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              src_valid_i,
  input  logic [DATA_W-1:0] src_data_i,
  input  logic [CTRL_W-1:0] src_ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

  // Next-state selection: kill, hold, or take the upstream slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall_i) begin
      valid_d = src_valid_i;
      ctrl_d  = src_valid_i ? src_ctrl_i : '0;
      if (src_valid_i) begin
        data_d = src_data_i;
      end
    end
  end

  // Slice registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register, DEPTH chained slices
// (1..PIPE_DEPTH_MAX) honouring hazard-unit stall and flush.
// Build option PIPE_STAGE_STATS_EN adds saturating stall/bubble counters;
// without it the counter ports read 0 and cnt_clr is ignored.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [DEPTH-1:0]  src_valid;
  logic [DATA_W-1:0] src_data [DEPTH];
  logic [CTRL_W-1:0] src_ctrl [DEPTH];
  logic [DEPTH-1:0]  slc_valid;
  logic [DATA_W-1:0] slc_data [DEPTH];
  logic [CTRL_W-1:0] slc_ctrl [DEPTH];

  assign src_valid[0] = in_valid;
  assign src_data[0]  = in_data;
  assign src_ctrl[0]  = in_ctrl;

  for (genvar i = 1; i < DEPTH; i++) begin : g_chain
    assign src_valid[i] = slc_valid[i-1];
    assign src_data[i]  = slc_data[i-1];
    assign src_ctrl[i]  = slc_ctrl[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slice
    pipe_stage_slice #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_slice (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall),
      .flush_i     (flush),
      .src_valid_i (src_valid[i]),
      .src_data_i  (src_data[i]),
      .src_ctrl_i  (src_ctrl[i]),
      .valid_o     (slc_valid[i]),
      .data_o      (slc_data[i]),
      .ctrl_o      (slc_ctrl[i])
    );
  end

  assign out_valid = slc_valid[DEPTH-1];
  assign out_data  = slc_data[DEPTH-1];
  assign out_ctrl  = slc_ctrl[DEPTH-1];

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Counter update: clear wins, otherwise saturating increments.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d  = '0;
      bubble_cnt_d = '0;
    end else begin
      if (stall && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (!stall && !out_valid && (bubble_cnt_q != '1)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end
    end
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign stall_cnt      = '0;
  assign bubble_cnt     = '0;
`endif

endmodule
